// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding and the frame constants
// common to the baud generator, transmitter and receiver.
`timescale 1ns/1ps
package uart_pkg;

   localparam int unsigned UART_OVERSAMPLE = 16;
   localparam int unsigned UART_DATA_BITS  = 8;

   typedef enum logic [2:0] {
      IDLE,
      START,
      DATA,
      STOP,
      WAIT_IDLE
   } rx_state_t;

   function automatic logic maj3(input logic a, input logic b, input logic c);
      return (a & b) | (a & c) | (b & c);
   endfunction

endpackage

// File: rtl/uart_sync2.sv
// Two-flop synchroniser for an asynchronous input, with a configurable reset
// value so an idle-high line does not look active coming out of reset.
`timescale 1ns/1ps
module uart_sync2 #(
   parameter logic RESET_VAL = 1'b1
) (
   input  logic clk,
   input  logic reset_n,
   input  logic d,
   output logic q
);

   logic meta_q;
   logic sync_q;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         meta_q <= RESET_VAL;
         sync_q <= RESET_VAL;
      end else begin
         meta_q <= d;
         sync_q <= meta_q;
      end
   end

   assign q = sync_q;

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver: oversampled start detection, 3-sample majority voting per
// bit, and a valid/ready output register with framing and overrun reporting.
`timescale 1ns/1ps
module uart_rx
   import uart_pkg::*;
#(
   parameter int unsigned DATA_BITS  = UART_DATA_BITS,
   parameter int unsigned OVERSAMPLE = UART_OVERSAMPLE
) (
   input  logic                 clk,
   input  logic                 reset_n,
   input  logic                 baud_x16_tk,
   input  logic                 rx_serial,
   output logic [DATA_BITS-1:0] rx_data,
   output logic                 rx_valid,
   input  logic                 rx_ready,
   output logic                 frame_error,
   output logic                 overrun,
   output logic                 rx_busy
);

   localparam int unsigned CNT_W = $clog2(OVERSAMPLE);
   localparam int unsigned IDX_W = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
   localparam logic [CNT_W-1:0] CNT_SMP0 = CNT_W'(OVERSAMPLE / 2 - 1);
   localparam logic [CNT_W-1:0] CNT_SMP1 = CNT_W'(OVERSAMPLE / 2);
   localparam logic [CNT_W-1:0] CNT_DEC  = CNT_W'(OVERSAMPLE / 2 + 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(OVERSAMPLE - 1);
   localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_BITS - 1);

   logic rx_s;

   uart_sync2 #(.RESET_VAL(1'b1)) u_sync (
      .clk     (clk),
      .reset_n (reset_n),
      .d       (rx_serial),
      .q       (rx_s)
   );

   rx_state_t            state_q,       state_d;
   logic [CNT_W-1:0]     cnt_q,         cnt_d;
   logic [IDX_W-1:0]     bit_idx_q,     bit_idx_d;
   logic [DATA_BITS-1:0] shreg_q,       shreg_d;
   logic [1:0]           smp_q,         smp_d;
   logic [DATA_BITS-1:0] rx_data_q,     rx_data_d;
   logic                 rx_valid_q,    rx_valid_d;
   logic                 frame_error_q, frame_error_d;
   logic                 overrun_q,     overrun_d;
   logic                 busy_q,        busy_d;

   logic maj;
   logic deliver;

   always_comb begin
      state_d       = state_q;
      cnt_d         = cnt_q;
      bit_idx_d     = bit_idx_q;
      shreg_d       = shreg_q;
      smp_d         = smp_q;
      rx_data_d     = rx_data_q;
      rx_valid_d    = rx_valid_q & ~rx_ready;
      frame_error_d = 1'b0;
      overrun_d     = 1'b0;
      deliver       = 1'b0;
      maj           = maj3(smp_q[1], smp_q[0], rx_s);

      if (baud_x16_tk) begin
         if (state_q == START || state_q == DATA || state_q == STOP) begin
            cnt_d = (cnt_q == CNT_LAST) ? '0 : cnt_q + 1'b1;
            if (cnt_q == CNT_SMP0) smp_d[1] = rx_s;
            if (cnt_q == CNT_SMP1) smp_d[0] = rx_s;
         end

         case (state_q)
            IDLE: begin
               if (!rx_s) begin
                  state_d = START;
                  cnt_d   = '0;
               end
            end
            START: begin
               if (cnt_q == CNT_DEC && maj) begin
                  state_d = IDLE;
                  cnt_d   = '0;
               end else if (cnt_q == CNT_LAST) begin
                  state_d   = DATA;
                  bit_idx_d = '0;
               end
            end
            DATA: begin
               if (cnt_q == CNT_DEC) shreg_d = {maj, shreg_q[DATA_BITS-1:1]};
               if (cnt_q == CNT_LAST) begin
                  if (bit_idx_q == IDX_LAST) state_d = STOP;
                  else bit_idx_d = bit_idx_q + 1'b1;
               end
            end
            STOP: begin
               // Leave at mid-stop so the next start edge can be caught early.
               if (cnt_q == CNT_DEC) begin
                  cnt_d = '0;
                  if (maj) begin
                     state_d = IDLE;
                     deliver = 1'b1;
                  end else begin
                     state_d       = WAIT_IDLE;
                     frame_error_d = 1'b1;
                  end
               end
            end
            WAIT_IDLE: begin
               if (rx_s) state_d = IDLE;
            end
            default: begin
               state_d = IDLE;
               cnt_d   = '0;
            end
         endcase
      end

      if (deliver) begin
         rx_valid_d = 1'b1;
         if (!rx_valid_q || rx_ready) rx_data_d = shreg_q;
         else overrun_d = 1'b1;
      end

      busy_d = (state_d != IDLE);
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q       <= IDLE;
         cnt_q         <= '0;
         bit_idx_q     <= '0;
         shreg_q       <= '0;
         smp_q         <= '0;
         rx_data_q     <= '0;
         rx_valid_q    <= 1'b0;
         frame_error_q <= 1'b0;
         overrun_q     <= 1'b0;
         busy_q        <= 1'b0;
      end else begin
         state_q       <= state_d;
         cnt_q         <= cnt_d;
         bit_idx_q     <= bit_idx_d;
         shreg_q       <= shreg_d;
         smp_q         <= smp_d;
         rx_data_q     <= rx_data_d;
         rx_valid_q    <= rx_valid_d;
         frame_error_q <= frame_error_d;
         overrun_q     <= overrun_d;
         busy_q        <= busy_d;
      end
   end

   assign rx_data     = rx_data_q;
   assign rx_valid    = rx_valid_q;
   assign frame_error = frame_error_q;
   assign overrun     = overrun_q;
   assign rx_busy     = busy_q;

endmodule
